ahb3lite_sram_slave: RTL and testbench
======================================

Name: ahb3lite_sram_slave

Overview:
AHB3-Lite slave fronting an on-chip byte-writable SRAM. It is the responder for the instruction and data AHB-Lite master ports of the RISC-V top, giving boot code and data memory on the same HCLK domain. It supports byte, halfword and word transfers, a configurable number of wait states, and a two-cycle ERROR response for illegal accesses. Write data is forwarded into back-to-back reads of the same word.

Parameters:
MEM_WORDS, 1024, SRAM depth in 32-bit words (power of two).
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to MEM_WORDS*4.
WAIT_STATES, 0, HREADYOUT-low cycles inserted at the start of every OKAY data phase (0..15).

Ports:
HCLK  in  1  clock; all logic on rising edge.
HRESET  in  1  synchronous, active-high reset.
HSEL  in  1  slave select from decoder.
HADDR  in  32  byte address.
HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
HWRITE  in  1  1=write.
HSIZE  in  3  0=byte, 1=half, 2=word; others illegal.
HBURST  in  3  accepted, ignored (each beat is handled independently).
HPROT  in  4  ignored.
HMASTLOCK  in  1  ignored.
HWDATA  in  32  write data (data phase).
HREADY  in  1  bus HREADY; an address phase is sampled only when HREADY=1.
HREADYOUT  out  1  slave ready.
HRESP  out  1  0=OKAY, 1=ERROR.
HRDATA  out  32  read data, full word; the master selects lanes.

Behaviour:
- Reset (HRESET=1 at an edge): HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, wait counter=0. Any pending write is discarded. SRAM contents are not cleared.
- Transfer accepted when HSEL & HREADY & HTRANS[1] at an edge. Register addr, write, size and byte-enables. IDLE, BUSY, or HSEL=0 gives a zero-wait OKAY with no access.
- Byte enables: byte -> 1<<HADDR[1:0]; half -> 4'b0011<<HADDR[1:0]; word -> 4'b1111.
- Illegal: HSIZE>2; half with HADDR[0]=1; word with HADDR[1:0]!=0; (HADDR-BASE_ADDR) >= MEM_WORDS*4. An illegal access causes no SRAM access.
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE: legal accept goes to WAIT if WAIT_STATES>0, else DATA. Illegal accept goes to ERR1.
  - WAIT: HREADYOUT=0, HRESP=0. Counter runs WAIT_STATES-1 down to 0, then DATA.
  - DATA: HREADYOUT=1, HRESP=0. This is the final data-phase cycle. A new accept in the same cycle follows the IDLE rules; otherwise go to IDLE.
  - ERR1: HREADYOUT=0, HRESP=1, then ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. Accept is evaluated as in IDLE. If the master drops to IDLE in ERR2, return to IDLE.
- Read: SRAM is read synchronously at the accepting edge. HRDATA is valid from the first data-phase cycle and held until the next read is loaded. Latency is zero wait states when WAIT_STATES=0.
- Write: HWDATA is committed to the SRAM with the registered byte-enables at the edge ending the DATA cycle. HWDATA in WAIT cycles is ignored.
- Forwarding: a read accepted at the same edge a write commits to the same word loads HRDATA from the merged word (HWDATA on the enabled bytes, old SRAM bytes elsewhere). It must never return stale data.
- Back-to-back NONSEQ/SEQ with WAIT_STATES=0 sustains one transfer per cycle.
- Word index = (HADDR-BASE_ADDR)[log2(MEM_WORDS*4)-1:2]. There is no wrap-around; out-of-range addresses return ERROR.
- HRESET asserted mid-WAIT or mid-ERR1: the next cycle is IDLE with HREADYOUT=1.

Decomposition:
- Shared package ahb3lite_pkg: HTRANS_*, HSIZE_*, HRESP_OKAY/ERROR constants, and the slave FSM state enum. Both this block and the existing master bridges import it.
- Sub-module ahb3lite_sram_bank: single-port synchronous SRAM with 4-bit byte-write enable, registered read data and read-during-write bypass. It is kept separate so it can be swapped for a BRAM macro.

Test Plan:
1. WAIT_STATES=0. Word write 0xDEADBEEF at BASE+0x10, then read BASE+0x10 back-to-back -> HREADYOUT stays 1 and HRDATA=0xDEADBEEF in the read data phase (forwarding path).
2. Byte write 0xAA at BASE+0x13 over word 0x11223344 -> subsequent word read returns 0xAA223344. Half write 0x5566 at BASE+0x12 -> read returns 0x55663344.
3. WAIT_STATES=2, single read -> HREADYOUT low for exactly 2 cycles, then high with correct HRDATA. A write under the same setting leaves the SRAM unchanged until the DATA-cycle edge.
4. Read at BASE+MEM_WORDS*4, and word access at BASE+0x2 -> HREADYOUT=0/HRESP=1 then HREADYOUT=1/HRESP=1, with SRAM unmodified.
5. HTRANS=BUSY with HSEL=1, then HSEL=0 NONSEQ -> zero-wait OKAY, no SRAM access, HRDATA unchanged.
6. Assert HRESET during the second of 3 wait states -> next cycle HREADYOUT=1, HRESP=0, HRDATA=0, and the pending write is not committed.

Source files
------------

// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite encodings and the slave FSM state type.
// Imported by the SRAM slave and by the master bridges.
package ahb3lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StData,
        StErr1,
        StErr2
    } slave_state_e;

endpackage

// File: rtl/ahb3lite_sram_bank.sv
// Byte-writable synchronous SRAM bank with registered read data.
// A read of the word being written in the same cycle returns the merged new word.
module ahb3lite_sram_bank #(
    parameter int unsigned Words = 1024,
    parameter int unsigned AddrW = $clog2(Words)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             re_i,
    input  logic [AddrW-1:0] raddr_i,
    input  logic             we_i,
    input  logic [3:0]       be_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem_q [Words];
    logic [31:0] rdata_q;
    logic [31:0] merged;

    always_comb begin
        merged = mem_q[raddr_i];
        if (we_i && (waddr_i == raddr_i)) begin
            for (int i = 0; i < 4; i++) begin
                if (be_i[i]) begin
                    merged[8*i +: 8] = wdata_i[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (be_i[i]) begin
                    mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= merged;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ahb3lite_sram_slave.sv
// AHB3-Lite slave in front of a byte-writable SRAM bank, with optional wait
// states, two-cycle ERROR response and write-to-read forwarding.
module ahb3lite_sram_slave
    import ahb3lite_pkg::*;
#(
    parameter int unsigned MEM_WORDS   = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic        HMASTLOCK,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    localparam int unsigned AddrW    = $clog2(MEM_WORDS);
    localparam logic [31:0] MemBytes = 32'(MEM_WORDS * 4);
    localparam bit          HasWait  = (WAIT_STATES != 0);
    localparam logic [3:0]  WaitInit = 4'(HasWait ? WAIT_STATES - 1 : 0);

    slave_state_e     state_q;
    logic [3:0]       wait_cnt_q;
    logic             hreadyout_q;
    logic             hresp_q;
    logic             write_q;
    logic [3:0]       be_q;
    logic [AddrW-1:0] addr_q;

    logic [31:0] offset;
    logic        ready_state;
    logic        take;
    logic        illegal;
    logic        legal_take;
    logic [3:0]  be;
    logic        bank_re;
    logic        bank_we;

    assign offset      = HADDR - BASE_ADDR;
    assign ready_state = (state_q == StIdle) || (state_q == StData) || (state_q == StErr2);
    assign take        = HSEL & HREADY & HTRANS[1] & ready_state;
    assign legal_take  = take & ~illegal;

    // Addresses below the base wrap to large offsets and fail the range check.
    always_comb begin
        illegal = (HSIZE > HSIZE_WORD)
                | ((HSIZE == HSIZE_HALF) & HADDR[0])
                | ((HSIZE == HSIZE_WORD) & (HADDR[1:0] != 2'b00))
                | (offset >= MemBytes);
        case (HSIZE)
            HSIZE_BYTE: be = 4'b0001 << HADDR[1:0];
            HSIZE_HALF: be = 4'b0011 << HADDR[1:0];
            default:    be = 4'b1111;
        endcase
    end

    assign bank_re = legal_take & ~HWRITE & ~HRESET;
    assign bank_we = (state_q == StData) & write_q & ~HRESET;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q     <= StIdle;
            wait_cnt_q  <= '0;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            write_q     <= 1'b0;
            be_q        <= '0;
            addr_q      <= '0;
        end else begin
            if (legal_take) begin
                addr_q  <= offset[AddrW+1:2];
                write_q <= HWRITE;
                be_q    <= be;
            end
            case (state_q)
                StWait: begin
                    if (wait_cnt_q == '0) begin
                        state_q     <= StData;
                        hreadyout_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 4'd1;
                    end
                end
                StErr1: begin
                    state_q     <= StErr2;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= HRESP_ERROR;
                end
                default: begin
                    // Idle, final data cycle and second error cycle all accept.
                    if (take && illegal) begin
                        state_q     <= StErr1;
                        hreadyout_q <= 1'b0;
                        hresp_q     <= HRESP_ERROR;
                    end else if (take && HasWait) begin
                        state_q     <= StWait;
                        wait_cnt_q  <= WaitInit;
                        hreadyout_q <= 1'b0;
                        hresp_q     <= HRESP_OKAY;
                    end else if (take) begin
                        state_q     <= StData;
                        hreadyout_q <= 1'b1;
                        hresp_q     <= HRESP_OKAY;
                    end else begin
                        state_q     <= StIdle;
                        hreadyout_q <= 1'b1;
                        hresp_q     <= HRESP_OKAY;
                    end
                end
            endcase
        end
    end

    ahb3lite_sram_bank #(
        .Words (MEM_WORDS),
        .AddrW (AddrW)
    ) u_bank (
        .clk_i   (HCLK),
        .rst_i   (HRESET),
        .re_i    (bank_re),
        .raddr_i (offset[AddrW+1:2]),
        .we_i    (bank_we),
        .be_i    (be_q),
        .waddr_i (addr_q),
        .wdata_i (HWDATA),
        .rdata_o (HRDATA)
    );

    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;

    logic unused_inputs;
    assign unused_inputs = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// Directed bench for ahb3lite_sram_slave: three instances with 0, 2 and 3
// wait states share clock and reset; each is driven as a lone slave.
module tb_ahb3lite_sram_slave;
    import ahb3lite_pkg::*;

    localparam logic [31:0] Base  = 32'h2000_0000;
    localparam int unsigned Words = 64;

    logic HCLK = 1'b0;
    logic HRESET = 1'b1;

    logic [2:0]       hsel, hwrite, hmastlock, hready, hreadyout, hresp;
    logic [2:0][31:0] haddr, hwdata, hrdata;
    logic [2:0][1:0]  htrans;
    logic [2:0][2:0]  hsize, hburst;
    logic [2:0][3:0]  hprot;

    int n_vec = 0;
    int n_err = 0;

    always #5 HCLK = ~HCLK;

    assign hready = hreadyout;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ahb3lite_sram_slave #(
            .MEM_WORDS   (Words),
            .BASE_ADDR   (Base),
            .WAIT_STATES ((g == 0) ? 0 : g + 1)
        ) u_dut (
            .HCLK      (HCLK),
            .HRESET    (HRESET),
            .HSEL      (hsel[g]),
            .HADDR     (haddr[g]),
            .HTRANS    (htrans[g]),
            .HWRITE    (hwrite[g]),
            .HSIZE     (hsize[g]),
            .HBURST    (hburst[g]),
            .HPROT     (hprot[g]),
            .HMASTLOCK (hmastlock[g]),
            .HWDATA    (hwdata[g]),
            .HREADY    (hready[g]),
            .HREADYOUT (hreadyout[g]),
            .HRESP     (hresp[g]),
            .HRDATA    (hrdata[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle_bus(input int d);
        hsel[d]   = 1'b0;
        htrans[d] = HTRANS_IDLE;
        hwrite[d] = 1'b0;
        haddr[d]  = Base;
        hsize[d]  = HSIZE_WORD;
    endtask

    // One isolated transfer; HWDATA carries junk while the slave stalls.
    task automatic xchk(input int d, input logic [31:0] off, input logic wr,
                        input logic [2:0] size, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_resp,
                        input int exp_waits, input string tag);
        int   waits;
        logic resp_w;
        hsel[d]   = 1'b1;
        htrans[d] = HTRANS_NONSEQ;
        haddr[d]  = Base + off;
        hwrite[d] = wr;
        hsize[d]  = size;
        tick();
        idle_bus(d);
        waits  = 0;
        resp_w = 1'b0;
        hwdata[d] = hreadyout[d] ? wd : ~wd;
        while (!hreadyout[d] && waits < 20) begin
            resp_w |= hresp[d];
            waits++;
            tick();
            hwdata[d] = hreadyout[d] ? wd : ~wd;
        end
        check({tag, "_waits"}, 32'(waits), 32'(exp_waits));
        check({tag, "_resp_stall"}, 32'(resp_w), 32'(exp_resp));
        check({tag, "_resp"}, 32'(hresp[d]), 32'(exp_resp));
        if (!wr && !exp_resp) begin
            check({tag, "_rdata"}, hrdata[d], exp_rd);
        end
        tick();
    endtask

    // Write immediately followed by a read of the same word.
    task automatic b2b(input int d, input logic [31:0] off, input logic [2:0] size,
                       input logic [31:0] wd, input logic [31:0] exp, input string tag);
        hsel[d]   = 1'b1;
        htrans[d] = HTRANS_NONSEQ;
        haddr[d]  = Base + off;
        hwrite[d] = 1'b1;
        hsize[d]  = size;
        tick();
        haddr[d]  = Base + {off[31:2], 2'b00};
        hwrite[d] = 1'b0;
        hsize[d]  = HSIZE_WORD;
        hwdata[d] = wd;
        check({tag, "_wr_ready"}, 32'(hreadyout[d]), 32'd1);
        tick();
        idle_bus(d);
        check({tag, "_rd_ready"}, 32'(hreadyout[d]), 32'd1);
        check({tag, "_rdata"}, hrdata[d], exp);
        tick();
    endtask

    initial begin
        hburst    = '0;
        hprot     = '0;
        hmastlock = '0;
        hwdata    = '0;
        for (int d = 0; d < 3; d++) idle_bus(d);
        tick();
        tick();
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst_ready%0d", d), 32'(hreadyout[d]), 32'd1);
            check($sformatf("rst_resp%0d", d), 32'(hresp[d]), 32'd0);
            check($sformatf("rst_rdata%0d", d), hrdata[d], 32'd0);
        end
        HRESET = 1'b0;

        // Forwarding of a word and of a single byte into back-to-back reads.
        b2b(0, 32'h10, HSIZE_WORD, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "fwd_word");
        xchk(0, 32'h10, 1'b0, HSIZE_WORD, 32'h0, 32'hDEAD_BEEF, 1'b0, 0, "rd_after_fwd");
        b2b(0, 32'h11, HSIZE_BYTE, 32'h0000_7700, 32'hDEAD_77EF, "fwd_byte");

        // Byte and halfword lane merging.
        xchk(0, 32'h10, 1'b1, HSIZE_WORD, 32'h1122_3344, 32'h0, 1'b0, 0, "wr_base_word");
        xchk(0, 32'h13, 1'b1, HSIZE_BYTE, 32'hAA00_0000, 32'h0, 1'b0, 0, "wr_byte3");
        xchk(0, 32'h10, 1'b0, HSIZE_WORD, 32'h0, 32'hAA22_3344, 1'b0, 0, "rd_byte3");
        xchk(0, 32'h12, 1'b1, HSIZE_HALF, 32'h5566_0000, 32'h0, 1'b0, 0, "wr_half_hi");
        xchk(0, 32'h10, 1'b0, HSIZE_WORD, 32'h0, 32'h5566_3344, 1'b0, 0, "rd_half_hi");
        xchk(0, 32'h10, 1'b1, HSIZE_HALF, 32'h0000_7788, 32'h0, 1'b0, 0, "wr_half_lo");
        xchk(0, 32'h10, 1'b0, HSIZE_WORD, 32'h0, 32'h5566_7788, 1'b0, 0, "rd_half_lo");
        xchk(0, 32'h00, 1'b1, HSIZE_WORD, 32'h0102_0304, 32'h0, 1'b0, 0, "wr_word0");

        // Two wait states.
        xchk(1, 32'h40, 1'b1, HSIZE_WORD, 32'hCAFE_F00D, 32'h0, 1'b0, 2, "ws2_wr");
        xchk(1, 32'h40, 1'b0, HSIZE_WORD, 32'h0, 32'hCAFE_F00D, 1'b0, 2, "ws2_rd");

        // Illegal accesses: two-cycle ERROR, SRAM untouched.
        xchk(0, 32'(Words * 4), 1'b0, HSIZE_WORD, 32'h0, 32'h0, 1'b1, 1, "err_oor");
        xchk(0, 32'hFFFF_FFFC, 1'b1, HSIZE_WORD, 32'hFFFF_FFFF, 32'h0, 1'b1, 1, "err_below");
        xchk(0, 32'h02, 1'b1, HSIZE_WORD, 32'hFFFF_FFFF, 32'h0, 1'b1, 1, "err_word_mis");
        xchk(0, 32'h11, 1'b1, HSIZE_HALF, 32'hFFFF_FFFF, 32'h0, 1'b1, 1, "err_half_mis");
        xchk(0, 32'h00, 1'b1, 3'd3, 32'hFFFF_FFFF, 32'h0, 1'b1, 1, "err_size");
        xchk(1, 32'h42, 1'b1, HSIZE_WORD, 32'hFFFF_FFFF, 32'h0, 1'b1, 1, "err_ws2");
        xchk(0, 32'h10, 1'b0, HSIZE_WORD, 32'h0, 32'h5566_7788, 1'b0, 0, "err_keep10");
        xchk(0, 32'h00, 1'b0, HSIZE_WORD, 32'h0, 32'h0102_0304, 1'b0, 0, "err_keep00");
        xchk(1, 32'h40, 1'b0, HSIZE_WORD, 32'h0, 32'hCAFE_F00D, 1'b0, 2, "err_keep40");

        // BUSY with HSEL, then NONSEQ without HSEL: no access, HRDATA held.
        hsel[0]   = 1'b1;
        htrans[0] = HTRANS_BUSY;
        hwrite[0] = 1'b1;
        haddr[0]  = Base;
        hsize[0]  = HSIZE_WORD;
        hwdata[0] = 32'hFFFF_FFFF;
        tick();
        check("busy_ready", 32'(hreadyout[0]), 32'd1);
        check("busy_resp", 32'(hresp[0]), 32'd0);
        check("busy_rdata", hrdata[0], 32'h0102_0304);
        hsel[0]   = 1'b0;
        htrans[0] = HTRANS_NONSEQ;
        tick();
        check("unsel_ready", 32'(hreadyout[0]), 32'd1);
        check("unsel_resp", 32'(hresp[0]), 32'd0);
        check("unsel_rdata", hrdata[0], 32'h0102_0304);
        idle_bus(0);
        tick();
        xchk(0, 32'h00, 1'b0, HSIZE_WORD, 32'h0, 32'h0102_0304, 1'b0, 0, "unsel_keep00");

        // Reset during the second of three wait states drops the write.
        xchk(2, 32'h80, 1'b1, HSIZE_WORD, 32'h600D_600D, 32'h0, 1'b0, 3, "ws3_wr");
        xchk(2, 32'h80, 1'b0, HSIZE_WORD, 32'h0, 32'h600D_600D, 1'b0, 3, "ws3_rd");
        hsel[2]   = 1'b1;
        htrans[2] = HTRANS_NONSEQ;
        haddr[2]  = Base + 32'h80;
        hwrite[2] = 1'b1;
        hsize[2]  = HSIZE_WORD;
        tick();
        idle_bus(2);
        hwdata[2] = 32'hBAAD_BAAD;
        check("rstw_wait1", 32'(hreadyout[2]), 32'd0);
        tick();
        check("rstw_wait2", 32'(hreadyout[2]), 32'd0);
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        check("rstw_ready", 32'(hreadyout[2]), 32'd1);
        check("rstw_resp", 32'(hresp[2]), 32'd0);
        check("rstw_rdata", hrdata[2], 32'd0);
        xchk(2, 32'h80, 1'b0, HSIZE_WORD, 32'h0, 32'h600D_600D, 1'b0, 3, "rstw_keep80");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
